// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter.
package mem_arb_pkg;

    localparam int unsigned WSTRB_W = 4;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StRsp  = 2'd2
    } state_e;

    typedef enum logic {
        OwnIfu = 1'b0,
        OwnLsu = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between IFU and LSU.
// On a tie the requester that was not granted last wins; history starts at IFU.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_ifu_i,
    input  logic req_lsu_i,
    input  logic upd_en_i,
    output logic gnt_ifu_o,
    output logic gnt_lsu_o
);

    owner_e last_q, last_d;

    // Grant decode from current requests and grant history.
    always_comb begin
        gnt_lsu_o = req_lsu_i & (~req_ifu_i | (last_q == OwnIfu));
        gnt_ifu_o = req_ifu_i & ~gnt_lsu_o;
    end

    // History only moves when the top actually accepts a request.
    always_comb begin
        last_d = last_q;
        if (upd_en_i) begin
            if (gnt_lsu_o) begin
                last_d = OwnLsu;
            end else if (gnt_ifu_o) begin
                last_d = OwnIfu;
            end
        end
    end

    // Grant history register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= OwnIfu;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store units.
// One outstanding transaction; a response that never arrives is replaced by an
// error response after TIMEOUT cycles in the response phase.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [XLEN-1:0]    ifu_req_addr,
    output logic               ifu_rsp_valid,
    output logic [XLEN-1:0]    ifu_rsp_rdata,
    output logic               ifu_rsp_err,

    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic               lsu_req_wen,
    input  logic [XLEN-1:0]    lsu_req_addr,
    input  logic [XLEN-1:0]    lsu_req_wdata,
    input  logic [WSTRB_W-1:0] lsu_req_wstrb,
    output logic               lsu_rsp_valid,
    output logic [XLEN-1:0]    lsu_rsp_rdata,
    output logic               lsu_rsp_err,

    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_wen,
    output logic [XLEN-1:0]    mem_req_addr,
    output logic [XLEN-1:0]    mem_req_wdata,
    output logic [WSTRB_W-1:0] mem_req_wstrb,
    input  logic               mem_rsp_valid,
    input  logic [XLEN-1:0]    mem_rsp_rdata
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    state_e               state_q, state_d;
    owner_e               owner_q, owner_d;
    logic                 wen_q, wen_d;
    logic [XLEN-1:0]      addr_q, addr_d;
    logic [XLEN-1:0]      wdata_q, wdata_d;
    logic [WSTRB_W-1:0]   wstrb_q, wstrb_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic is_idle;
    logic gnt_ifu, gnt_lsu;
    logic accept;
    logic timeout_hit;
    logic rsp_fire;

    // Requests are only offered to the arbiter while idle and out of reset.
    always_comb begin
        is_idle     = (state_q == StIdle) & ~rst;
        accept      = gnt_ifu | gnt_lsu;
        timeout_hit = (state_q == StRsp) & (cnt_q == TimeoutCnt);
        // Real data wins over a timeout landing in the same cycle.
        rsp_fire    = ~rst & (state_q == StRsp) & (mem_rsp_valid | timeout_hit);
    end

    rr_arb2 u_rr_arb2 (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_ifu_i (ifu_req_valid & is_idle),
        .req_lsu_i (lsu_req_valid & is_idle),
        .upd_en_i  (is_idle),
        .gnt_ifu_o (gnt_ifu),
        .gnt_lsu_o (gnt_lsu)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory responses outside RSP fall through unused.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)        state_d = StReq;
            StReq:   if (mem_req_ready) state_d = StRsp;
            StRsp:   if (rsp_fire)      state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    // Request capture on accept and response-phase cycle counter.
    always_comb begin
        owner_d = owner_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        if (accept) begin
            owner_d = gnt_lsu ? OwnLsu : OwnIfu;
            wen_d   = gnt_lsu & lsu_req_wen;
            addr_d  = gnt_lsu ? lsu_req_addr : ifu_req_addr;
            // Fetches never write: clear store-only fields.
            wdata_d = gnt_lsu ? lsu_req_wdata : '0;
            wstrb_d = gnt_lsu ? lsu_req_wstrb : '0;
        end
        if ((state_q == StReq) && mem_req_ready) begin
            cnt_d = '0;
        end else if ((state_q == StRsp) && !mem_rsp_valid && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Latched request fields and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OwnIfu;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs: handshakes, memory request, and owner-steered response.
    always_comb begin
        ifu_req_ready = gnt_ifu;
        lsu_req_ready = gnt_lsu;

        mem_req_valid = ~rst & (state_q == StReq);
        mem_req_wen   = wen_q;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        mem_req_wstrb = wstrb_q;

        ifu_rsp_valid = rsp_fire & (owner_q == OwnIfu);
        lsu_rsp_valid = rsp_fire & (owner_q == OwnLsu);
        ifu_rsp_err   = ifu_rsp_valid & ~mem_rsp_valid;
        lsu_rsp_err   = lsu_rsp_valid & ~mem_rsp_valid;
        ifu_rsp_rdata = (ifu_rsp_valid & mem_rsp_valid) ? mem_rsp_rdata : '0;
        lsu_rsp_rdata = (lsu_rsp_valid & mem_rsp_valid) ? mem_rsp_rdata : '0;
    end

endmodule
